// File: rtl/z88_mem_pkg.sv
// Shared types and constants for the Z88 external memory arbiter.
// Holds the arbiter state encoding and the address region codes.
package z88_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_C_ACC  = 2'd1,
    ST_V_ACC  = 2'd2,
    ST_C_HOLD = 2'd3
  } arb_state_e;

  localparam logic [2:0] REG_ROM    = 3'b000;
  localparam logic [2:0] REG_RAM    = 3'b001;
  localparam logic [7:0] NONE_RDATA = 8'hFF;

endpackage

// File: rtl/z88_mem_decode.sv
// Region decode of a 22-bit translated address into ROM / RAM selects.
// Anything outside the two low 512K regions decodes to neither.
module z88_mem_decode
  import z88_mem_pkg::*;
(
  input  logic [21:0] addr_i,
  output logic        is_rom_o,
  output logic        is_ram_o
);

  // The chip offset is routed around this block; only the region bits matter.
  logic unused_offset;
  assign unused_offset = ^addr_i[18:0];

  assign is_rom_o = (addr_i[21:19] == REG_ROM);
  assign is_ram_o = (addr_i[21:19] == REG_RAM);

endmodule

// File: rtl/z88_mem_arbiter.sv
// Arbitrates the single external SRAM/ROM bus between the Z80 and the LCD
// fetch engine, sequencing setup/strobe/capture with registered strobes.
module z88_mem_arbiter
  import z88_mem_pkg::*;
#(
  parameter int unsigned ACC_CYCLES = 2,
  parameter int unsigned VID_STARVE = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [21:0] cpu_a_i,
  input  logic [7:0]  cpu_wdata_i,
  output logic [7:0]  cpu_rdata_o,
  output logic        cpu_wait_n_o,
  input  logic        vid_req_i,
  input  logic [21:0] vid_a_i,
  output logic        vid_ack_o,
  output logic [7:0]  vid_rdata_o,
  output logic [18:0] mem_a_o,
  output logic [7:0]  mem_do_o,
  input  logic [7:0]  mem_di_ram_i,
  input  logic [7:0]  mem_di_rom_i,
  output logic        ram_ce_n_o,
  output logic        rom_ce_n_o,
  output logic        mem_oe_n_o,
  output logic        mem_we_n_o
);

  localparam logic [2:0] CNT_LAST   = 3'(ACC_CYCLES - 1);
  localparam logic [3:0] STARVE_MAX = 4'(VID_STARVE);

  arb_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  starve_q, starve_d;
  logic        wr_q, wr_d;
  logic        rom_q, rom_d;
  logic        ram_q, ram_d;
  logic [18:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_do_q, mem_do_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic [7:0]  vid_rdata_q, vid_rdata_d;
  logic        vid_ack_q, vid_ack_d;
  logic        ram_ce_n_q, ram_ce_n_d;
  logic        rom_ce_n_q, rom_ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;

  logic        grant_vid;
  logic        grant_any;
  logic        grant_wr;
  logic [21:0] grant_a;
  logic        dec_rom;
  logic        dec_ram;
  logic        acc_last;
  logic [7:0]  rd_data;

  // Video wins only when the CPU is idle or has used up its starvation budget.
  assign grant_vid = vid_req_i & (~cpu_req_i | (starve_q == STARVE_MAX));
  assign grant_any = vid_req_i | cpu_req_i;
  assign grant_wr  = ~grant_vid & cpu_we_i;
  assign grant_a   = grant_vid ? vid_a_i : cpu_a_i;

  z88_mem_decode u_decode (
    .addr_i   (grant_a),
    .is_rom_o (dec_rom),
    .is_ram_o (dec_ram)
  );

  // Unmapped accesses have nothing to wait for, so they end after one clock.
  assign acc_last = (~rom_q & ~ram_q) | (cnt_q == CNT_LAST);
  assign rd_data  = ram_q ? mem_di_ram_i : (rom_q ? mem_di_rom_i : NONE_RDATA);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    wr_d        = wr_q;
    rom_d       = rom_q;
    ram_d       = ram_q;
    mem_a_d     = mem_a_q;
    mem_do_d    = mem_do_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    vid_ack_d   = 1'b0;
    ram_ce_n_d  = ram_ce_n_q;
    rom_ce_n_d  = rom_ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;

    case (state_q)
      ST_IDLE: begin
        if (!vid_req_i) begin
          starve_d = 4'd0;
        end
        if (grant_any) begin
          cnt_d      = 3'd0;
          wr_d       = grant_wr;
          rom_d      = dec_rom;
          ram_d      = dec_ram;
          mem_a_d    = grant_a[18:0];
          ram_ce_n_d = ~dec_ram;
          rom_ce_n_d = ~dec_rom;
          oe_n_d     = ~((dec_rom | dec_ram) & ~grant_wr);
          we_n_d     = 1'b1;
          if (grant_vid) begin
            state_d  = ST_V_ACC;
            starve_d = 4'd0;
          end else begin
            state_d  = ST_C_ACC;
            mem_do_d = cpu_wdata_i;
            if (vid_req_i && (starve_q != STARVE_MAX)) begin
              starve_d = starve_q + 4'd1;
            end
          end
        end
      end

      ST_C_ACC, ST_V_ACC: begin
        if (acc_last) begin
          ram_ce_n_d = 1'b1;
          rom_ce_n_d = 1'b1;
          oe_n_d     = 1'b1;
          we_n_d     = 1'b1;
          if (state_q == ST_C_ACC) begin
            state_d = ST_C_HOLD;
            if (!wr_q) begin
              cpu_rdata_d = rd_data;
            end
          end else begin
            state_d     = ST_IDLE;
            vid_rdata_d = rd_data;
            vid_ack_d   = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q + 3'd1;
          // First clock of a write is address/data setup; we_n follows it.
          we_n_d = ~(wr_q & ram_q);
        end
      end

      ST_C_HOLD: begin
        if (!cpu_req_i) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      starve_q    <= 4'd0;
      wr_q        <= 1'b0;
      rom_q       <= 1'b0;
      ram_q       <= 1'b0;
      mem_a_q     <= 19'd0;
      mem_do_q    <= 8'd0;
      cpu_rdata_q <= 8'd0;
      vid_rdata_q <= 8'd0;
      vid_ack_q   <= 1'b0;
      ram_ce_n_q  <= 1'b1;
      rom_ce_n_q  <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      wr_q        <= wr_d;
      rom_q       <= rom_d;
      ram_q       <= ram_d;
      mem_a_q     <= mem_a_d;
      mem_do_q    <= mem_do_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
      vid_ack_q   <= vid_ack_d;
      ram_ce_n_q  <= ram_ce_n_d;
      rom_ce_n_q  <= rom_ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
    end
  end

  assign cpu_wait_n_o = ~(cpu_req_i & (state_q != ST_C_HOLD));
  assign cpu_rdata_o  = cpu_rdata_q;
  assign vid_ack_o    = vid_ack_q;
  assign vid_rdata_o  = vid_rdata_q;
  assign mem_a_o      = mem_a_q;
  assign mem_do_o     = mem_do_q;
  assign ram_ce_n_o   = ram_ce_n_q;
  assign rom_ce_n_o   = rom_ce_n_q;
  assign mem_oe_n_o   = oe_n_q;
  assign mem_we_n_o   = we_n_q;

endmodule

// File: tb/tb_z88_mem_arbiter.sv
// Directed bench for z88_mem_arbiter: CPU/video read data checked through
// scoreboard queues, strobe activity and grant order tracked every clock.
module tb_z88_mem_arbiter;
  import z88_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [21:0] cpu_a;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_wait_n;
  logic        vid_req;
  logic [21:0] vid_a;
  logic        vid_ack;
  logic [7:0]  vid_rdata;
  logic [18:0] mem_a;
  logic [7:0]  mem_do;
  logic [7:0]  mem_di_ram, mem_di_rom;
  logic        ram_ce_n, rom_ce_n, mem_oe_n, mem_we_n;

  int total = 0;
  int bad   = 0;

  // activity counters, updated only by tick()
  int  cyc = 0;
  int  n_ram_ce = 0, n_rom_ce = 0, n_oe = 0, n_we = 0, n_we_pulse = 0, n_ack = 0;
  int  s_ram, s_rom, s_oe, s_we, s_wep, s_ack;
  logic we_prev = 1'b1;
  logic ce_prev = 1'b0;
  logic grant_chk = 1'b0;

  logic [7:0] cpu_exp[$];
  logic [7:0] vid_exp[$];
  byte        grant_exp[$];

  always #5 clk = ~clk;

  // Simple memory model: data is a fixed function of the address.
  assign mem_di_ram = mem_a[7:0] ^ 8'h5A;
  assign mem_di_rom = mem_a[7:0] ^ 8'hA5;

  z88_mem_arbiter #(.ACC_CYCLES(2), .VID_STARVE(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpu_req_i    (cpu_req),
    .cpu_we_i     (cpu_we),
    .cpu_a_i      (cpu_a),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_rdata_o  (cpu_rdata),
    .cpu_wait_n_o (cpu_wait_n),
    .vid_req_i    (vid_req),
    .vid_a_i      (vid_a),
    .vid_ack_o    (vid_ack),
    .vid_rdata_o  (vid_rdata),
    .mem_a_o      (mem_a),
    .mem_do_o     (mem_do),
    .mem_di_ram_i (mem_di_ram),
    .mem_di_rom_i (mem_di_rom),
    .ram_ce_n_o   (ram_ce_n),
    .rom_ce_n_o   (rom_ce_n),
    .mem_oe_n_o   (mem_oe_n),
    .mem_we_n_o   (mem_we_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample just after the falling edge, update activity counters.
  task automatic tick();
    logic ce_any;
    byte  g;
    @(negedge clk);
    #1;
    cyc++;
    if (!ram_ce_n) n_ram_ce++;
    if (!rom_ce_n) n_rom_ce++;
    if (!mem_oe_n) n_oe++;
    if (!mem_we_n) n_we++;
    if (!mem_we_n && we_prev) n_we_pulse++;
    we_prev = mem_we_n;
    ce_any = !ram_ce_n || !rom_ce_n;
    if (ce_any && !ce_prev && grant_chk && grant_exp.size() > 0) begin
      g = (mem_a[9:8] == 2'b10) ? "V" : "C";
      chk("grant_order", 32'(g), 32'(grant_exp.pop_front()));
    end
    ce_prev = ce_any;
    if (vid_ack) begin
      n_ack++;
      if (vid_exp.size() == 0) chk("vid_ack_unexpected", 32'(vid_ack), 32'd0);
      else chk("vid_rdata", 32'(vid_rdata), 32'(vid_exp.pop_front()));
    end
  endtask

  task automatic snap();
    s_ram = n_ram_ce; s_rom = n_rom_ce; s_oe = n_oe;
    s_we = n_we; s_wep = n_we_pulse; s_ack = n_ack;
  endtask

  // Issue one CPU cycle from IDLE; optionally keep cpu_req held after completion.
  task automatic cpu_access(input logic we, input logic [21:0] a, input logic [7:0] wd,
                            input logic [7:0] exp_rd, input int hold, output int wait_lo);
    logic done;
    cpu_we = we; cpu_a = a; cpu_wdata = wd; cpu_req = 1'b1;
    if (!we) cpu_exp.push_back(exp_rd);
    wait_lo = 0;
    #1;
    if (!cpu_wait_n) wait_lo++;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (cpu_wait_n) done = 1'b1;
      else wait_lo++;
    end
    chk("cpu_done", 32'(done), 32'd1);
    if (done && !we) chk("cpu_rdata", 32'(cpu_rdata), 32'(cpu_exp.pop_front()));
    for (int i = 0; i < hold; i++) tick();
    cpu_req = 1'b0;
    tick();
  endtask

  initial begin
    int wl, k, ack0, a1, a2, a3;
    logic got;
    reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = '0; cpu_wdata = '0;
    vid_req = 1'b0; vid_a = '0;
    repeat (3) tick();
    chk("rst_ram_ce_n", 32'(ram_ce_n), 32'd1);
    chk("rst_rom_ce_n", 32'(rom_ce_n), 32'd1);
    chk("rst_oe_n", 32'(mem_oe_n), 32'd1);
    chk("rst_we_n", 32'(mem_we_n), 32'd1);
    chk("rst_mem_a", 32'(mem_a), 32'd0);
    chk("rst_mem_do", 32'(mem_do), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_vid_rdata", 32'(vid_rdata), 32'd0);
    chk("rst_vid_ack", 32'(vid_ack), 32'd0);
    chk("rst_wait_n", 32'(cpu_wait_n), 32'd1);
    reset_n = 1'b1;
    tick();

    // CPU RAM read
    snap();
    cpu_access(1'b0, 22'h080123, 8'h00, 8'h23 ^ 8'h5A, 0, wl);
    chk("ramrd_wait_lo", 32'(wl), 32'd3);
    chk("ramrd_ce", 32'(n_ram_ce - s_ram), 32'd2);
    chk("ramrd_oe", 32'(n_oe - s_oe), 32'd2);
    chk("ramrd_rom_ce", 32'(n_rom_ce - s_rom), 32'd0);
    chk("ramrd_we", 32'(n_we - s_we), 32'd0);

    // CPU ROM write: chip enabled, never a write strobe
    snap();
    cpu_access(1'b1, 22'h000010, 8'hC3, 8'h00, 0, wl);
    chk("romwr_wait_lo", 32'(wl), 32'd3);
    chk("romwr_rom_ce", 32'(n_rom_ce - s_rom), 32'd2);
    chk("romwr_ram_ce", 32'(n_ram_ce - s_ram), 32'd0);
    chk("romwr_we", 32'(n_we - s_we), 32'd0);
    chk("romwr_oe", 32'(n_oe - s_oe), 32'd0);

    // CPU RAM write
    snap();
    cpu_access(1'b1, 22'h080055, 8'h3C, 8'h00, 0, wl);
    chk("ramwr_ce", 32'(n_ram_ce - s_ram), 32'd2);
    chk("ramwr_we_clks", 32'(n_we - s_we), 32'd1);
    chk("ramwr_oe", 32'(n_oe - s_oe), 32'd0);
    chk("ramwr_mem_do", 32'(mem_do), 32'h3C);
    chk("ramwr_mem_a", 32'(mem_a), 32'h00055);

    // CPU ROM read
    cpu_access(1'b0, 22'h000077, 8'h00, 8'h77 ^ 8'hA5, 0, wl);

    // Unmapped read and write
    snap();
    cpu_access(1'b0, 22'h200000, 8'h00, 8'hFF, 0, wl);
    chk("none_wait_lo", 32'(wl), 32'd2);
    cpu_access(1'b1, 22'h3FFFFF, 8'h11, 8'h00, 0, wl);
    chk("none_strobes", 32'((n_ram_ce - s_ram) + (n_rom_ce - s_rom) + (n_oe - s_oe) + (n_we - s_we)), 32'd0);

    // Single video fetch
    snap();
    vid_a = 22'h080245; vid_req = 1'b1; vid_exp.push_back(8'h45 ^ 8'h5A);
    for (int i = 0; i < 20 && n_ack == s_ack; i++) tick();
    vid_req = 1'b0;
    repeat (4) tick();
    chk("vid1_acks", 32'(n_ack - s_ack), 32'd1);
    chk("vid1_oe", 32'(n_oe - s_oe), 32'd2);

    // Back-to-back video, no CPU demand
    snap();
    a1 = 0; a2 = 0; a3 = 0;
    vid_a = 22'h080210; vid_req = 1'b1;
    repeat (3) vid_exp.push_back(8'h10 ^ 8'h5A);
    for (int i = 0; i < 40 && (n_ack - s_ack) < 3; i++) begin
      tick();
      if (vid_ack && (n_ack - s_ack) == 1) a1 = cyc;
      if (vid_ack && (n_ack - s_ack) == 2) a2 = cyc;
      if (vid_ack && (n_ack - s_ack) == 3) a3 = cyc;
    end
    vid_req = 1'b0;
    tick();
    chk("b2b_acks", 32'(n_ack - s_ack), 32'd3);
    chk("b2b_gap1", 32'(a2 - a1), 32'd3);
    chk("b2b_gap2", 32'(a3 - a2), 32'd3);

    // Both requesting continuously: C,C,C,C,V repeating
    snap();
    grant_chk = 1'b1;
    repeat (3) begin
      grant_exp.push_back("C"); grant_exp.push_back("C"); grant_exp.push_back("C");
      grant_exp.push_back("C"); grant_exp.push_back("V");
      vid_exp.push_back(8'h00 ^ 8'h5A);
    end
    k = 0;
    vid_a = 22'h080200; vid_req = 1'b1;
    cpu_we = 1'b0; cpu_a = 22'h080100; cpu_exp.push_back(8'h00 ^ 8'h5A); cpu_req = 1'b1;
    for (int i = 0; i < 200 && (n_ack - s_ack) < 3; i++) begin
      tick();
      if (cpu_req && cpu_wait_n) begin
        chk("cont_cpu_rdata", 32'(cpu_rdata), 32'(cpu_exp.pop_front()));
        cpu_req = 1'b0;
      end else if (!cpu_req) begin
        k++;
        cpu_a = 22'h080100 + 22'(k);
        cpu_exp.push_back(8'(k) ^ 8'h5A);
        cpu_req = 1'b1;
      end
    end
    vid_req = 1'b0;
    chk("cont_acks", 32'(n_ack - s_ack), 32'd3);
    chk("cont_grants_left", 32'(grant_exp.size()), 32'd0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got && cpu_req; i++) begin
      tick();
      if (cpu_wait_n) begin
        chk("cont_cpu_rdata", 32'(cpu_rdata), 32'(cpu_exp.pop_front()));
        cpu_req = 1'b0;
        got = 1'b1;
      end
    end
    tick();
    grant_chk = 1'b0;
    chk("cont_cpu_drained", 32'(cpu_exp.size()), 32'd0);

    // CPU holds cpu_req after a write; video must wait for it to drop
    snap();
    vid_a = 22'h080233; vid_req = 1'b1; vid_exp.push_back(8'h33 ^ 8'h5A);
    cpu_access(1'b1, 22'h080066, 8'h99, 8'h00, 10, wl);
    chk("hold_we_pulses", 32'(n_we_pulse - s_wep), 32'd1);
    chk("hold_no_early_vid", 32'(n_ack - s_ack), 32'd0);
    chk("hold_mem_do", 32'(mem_do), 32'h99);
    for (int i = 0; i < 10 && n_ack == s_ack; i++) tick();
    vid_req = 1'b0;
    tick();
    chk("hold_vid_after", 32'(n_ack - s_ack), 32'd1);

    // Reset in the middle of a video access
    snap();
    vid_a = 22'h080211; vid_req = 1'b1;
    tick();
    tick();
    chk("rst_mid_active", 32'(ram_ce_n), 32'd0);
    reset_n = 1'b0; vid_req = 1'b0;
    tick();
    chk("rst_mid_ram_ce_n", 32'(ram_ce_n), 32'd1);
    chk("rst_mid_oe_n", 32'(mem_oe_n), 32'd1);
    chk("rst_mid_we_n", 32'(mem_we_n), 32'd1);
    chk("rst_mid_rom_ce_n", 32'(rom_ce_n), 32'd1);
    chk("rst_mid_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("rst_mid_starve", 32'(dut.starve_q), 32'd0);
    reset_n = 1'b1;
    repeat (5) tick();
    chk("rst_mid_no_ack", 32'(n_ack - s_ack), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
